// File: rtl/ram_arbiter_if.sv
// RAM states shared with the memory model, and the cache/RAM bundle seen by ram_arbiter.
// master = arbiter side, slave = caches plus RAM.
package cpu_types_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

interface ram_arbiter_if #(parameter int CPUS = 2);
  import cpu_types_pkg::*;
  logic [CPUS-1:0]        iREN, dREN, dWEN;
  logic [CPUS-1:0][31:0]  iaddr, daddr, dstore;
  logic [CPUS-1:0]        iwait, dwait;
  logic [CPUS-1:0][31:0]  iload, dload;
  logic                   ramREN, ramWEN;
  logic [31:0]            ramaddr, ramstore, ramload;
  ramstate_t              ramstate;
  logic                   to_err;

  modport master (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, to_err
  );
  modport slave (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, to_err
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter for one RAM port shared by CPUS cores (I and D ports, D first, dWEN over dREN).
// Optional RAM_TIMEOUT_EN forces completion after TO_CYC stalled GRANT cycles and pulses to_err.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int TO_CYC = 64
) (
  input logic            CLK,
  input logic            RST,
  ram_arbiter_if.master  bus
);
  localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   gnt_cpu, last, last_n, win;
  logic            gnt_d, win_d, found;
  logic [CPUS-1:0] any_req;
  logic            req_live, done, to_fire;
  int              idx;

`ifdef RAM_TIMEOUT_EN
  localparam int TOW = $clog2(TO_CYC + 1);
  logic [TOW-1:0] to_cnt;

  // Held at zero outside GRANT, so every grant starts counting from zero.
  always_ff @(posedge CLK) begin
    if (RST || state != GRANT) to_cnt <= '0;
    else                       to_cnt <= to_cnt + 1'b1;
  end
  assign to_fire = (state == GRANT) && (to_cnt == TOW'(TO_CYC - 1));
`else
  logic [31:0] unused_to_cyc;
  assign unused_to_cyc = TO_CYC;
  assign to_fire = 1'b0;
`endif

  assign any_req = bus.iREN | bus.dREN | bus.dWEN;

  // Rotating scan starting one past the last completed core.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= CPUS; i++) begin
      idx = (int'(last) + i) % CPUS;
      if (!found && any_req[idx]) begin
        win   = CW'(idx);
        found = 1'b1;
      end
    end
    win_d = bus.dREN[win] | bus.dWEN[win];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      last    <= CW'(CPUS - 1);
      gnt_cpu <= '0;
      gnt_d   <= 1'b0;
    end else begin
      state <= state_n;
      last  <= last_n;
      if (state == IDLE && found) begin
        gnt_cpu <= win;
        gnt_d   <= win_d;
      end
    end
  end

  always_comb begin
    state_n      = state;
    last_n       = last;
    bus.iwait    = '1;
    bus.dwait    = '1;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.to_err   = 1'b0;
    bus.iload    = {CPUS{bus.ramload}};
    bus.dload    = {CPUS{bus.ramload}};
    req_live     = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: if (found) state_n = GRANT;
      GRANT: begin
        if (gnt_d && bus.dWEN[gnt_cpu]) begin
          bus.ramWEN   = 1'b1;
          bus.ramaddr  = bus.daddr[gnt_cpu];
          bus.ramstore = bus.dstore[gnt_cpu];
        end else if (gnt_d) begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.daddr[gnt_cpu];
        end else begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr[gnt_cpu];
        end
        req_live = gnt_d ? (bus.dREN[gnt_cpu] | bus.dWEN[gnt_cpu]) : bus.iREN[gnt_cpu];
        // A withdrawn request abandons the grant without a wait pulse or rotation.
        if (!req_live) begin
          state_n = IDLE;
        end else if (bus.ramstate == ACCESS || to_fire) begin
          done       = 1'b1;
          bus.to_err = to_fire && (bus.ramstate != ACCESS);
          state_n    = IDLE;
          last_n     = gnt_cpu;
        end
        if (done && gnt_d)  bus.dwait[gnt_cpu] = 1'b0;
        if (done && !gnt_d) bus.iwait[gnt_cpu] = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
